// File: rtl/cfib_seq_ctrl_if.sv
// Job request and result byte-stream bundle for the Fibonacci sequencer.
// The master side issues jobs and consumes bytes; the slave is the sequencer.
interface cfib_seq_ctrl_if #(
  parameter int NBITS = 6
);
  logic             start;
  logic [NBITS-1:0] n;
  logic             busy;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             done;
  logic             overflow;

  modport master (
    output start, n, out_ready,
    input  busy, out_data, out_valid, done, overflow
  );

  modport slave (
    input  start, n, out_ready,
    output busy, out_data, out_valid, done, overflow
  );
endinterface

// File: rtl/cfib_seq_ctrl.sv
// Fibonacci sequencer: n add/shift steps, then the result goes out LSB byte first.
// First byte valid n+1 cycles after start; each byte holds until out_ready, ena=0 freezes all.
module cfib_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int NBITS = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  cfib_seq_ctrl_if.slave  bus
);

  localparam int NB = WIDTH / 8;
  localparam int KW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic [NBITS-1:0] r_cnt;
  logic [KW-1:0]    r_k;
  logic             r_ovf_a;
  logic             r_ovf_b;
  logic             r_overflow;
  logic             r_done;

  logic [WIDTH:0]   w_sum;
  logic             w_valid;
  logic [7:0]       w_byte;

  // Extra top bit of the sum is the wrap carry for the b register.
  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  assign w_valid = ena && (r_state == S_EMIT);
  assign w_byte  = r_result[{r_k, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= WIDTH'(1);
      r_result   <= '0;
      r_cnt      <= '0;
      r_k        <= '0;
      r_ovf_a    <= 1'b0;
      r_ovf_b    <= 1'b0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else if (ena) begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cnt      <= bus.n;
            r_a        <= '0;
            r_b        <= WIDTH'(1);
            r_ovf_a    <= 1'b0;
            r_ovf_b    <= 1'b0;
            r_overflow <= 1'b0;
            r_state    <= S_ITER;
          end
        end
        S_ITER: begin
          if (r_cnt != '0) begin
            r_a     <= r_b;
            r_b     <= w_sum[WIDTH-1:0];
            r_cnt   <= r_cnt - NBITS'(1);
            // a inherits b's wrap history, so only a wrap of F(n) reaches overflow.
            r_ovf_b <= r_ovf_b | w_sum[WIDTH];
            r_ovf_a <= r_ovf_b;
          end else begin
            r_result   <= r_a;
            r_overflow <= r_ovf_a;
            r_k        <= '0;
            r_state    <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            if (r_k == K_LAST) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_valid ? w_byte : 8'd0;
  assign bus.done      = r_done;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_cfib_seq_ctrl.sv
// Directed bench for cfib_seq_ctrl: latency, byte order, overflow, backpressure,
// ena stall, start filtering, back-to-back jobs and asynchronous reset.
module tb_cfib_seq_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  cfib_seq_ctrl_if #(.NBITS(6)) bus ();

  cfib_seq_ctrl #(.WIDTH(32), .NBITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%h, expected 0x%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [5:0] nv);
    bus.n     = nv;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Edges counted after the start edge until out_valid is seen.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic collect(output logic [31:0] v);
    v = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = 0;
      while (bus.out_valid !== 1'b1 && g < 200) begin
        tick();
        g++;
      end
      v[i*8 +: 8] = bus.out_data;
      tick();
    end
  endtask

  task automatic run_job(input string tag, input logic [5:0] nv, input logic [31:0] exp_v,
                         input logic exp_ovf, input int exp_lat);
    int          lat;
    logic [31:0] v;
    bus.out_ready = 1'b1;
    start_job(nv);
    wait_valid(lat);
    check($sformatf("%s.latency", tag), lat, exp_lat);
    collect(v);
    check($sformatf("%s.value", tag), v, exp_v);
    check($sformatf("%s.done", tag), {31'd0, bus.done}, 32'd1);
    check($sformatf("%s.busy", tag), {31'd0, bus.busy}, 32'd0);
    check($sformatf("%s.overflow", tag), {31'd0, bus.overflow}, {31'd0, exp_ovf});
  endtask

  initial begin
    int          lat;
    int          hold_ok;
    logic [31:0] v;
    logic [31:0] exp20;
    logic [7:0]  eb;

    bus.start     = 1'b0;
    bus.n         = '0;
    bus.out_ready = 1'b1;
    exp20         = 32'h0000_1A6D;

    #12;
    check("reset.busy",      {31'd0, bus.busy},      32'd0);
    check("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset.out_data",  {24'd0, bus.out_data},  32'd0);
    check("reset.done",      {31'd0, bus.done},      32'd0);
    check("reset.overflow",  {31'd0, bus.overflow},  32'd0);
    rst_n = 1'b1;
    tick();

    // Basic job, then done must fall after one cycle.
    run_job("n10", 6'd10, 32'h0000_0037, 1'b0, 11);
    tick();
    check("n10.done_one_cycle", {31'd0, bus.done}, 32'd0);
    check("n10.idle_busy",      {31'd0, bus.busy}, 32'd0);

    run_job("n0", 6'd0, 32'h0000_0000, 1'b0, 1);
    run_job("n1", 6'd1, 32'h0000_0001, 1'b0, 2);

    // Overflow boundary: F(47) fits, F(48) wraps.
    run_job("n47", 6'd47, 32'hB119_24E1, 1'b0, 48);
    run_job("n48", 6'd48, 32'h1E8D_0A40, 1'b1, 49);
    tick();
    check("n48.overflow_held", {31'd0, bus.overflow}, 32'd1);
    run_job("n5", 6'd5, 32'h0000_0005, 1'b0, 6);

    // Backpressure: each byte held 5 cycles before a single-cycle ready.
    tick();
    bus.out_ready = 1'b0;
    start_job(6'd20);
    wait_valid(lat);
    check("bp.latency", lat, 21);
    for (int i = 0; i < 4; i++) begin
      eb = exp20[i*8 +: 8];
      hold_ok = 1;
      repeat (5) begin
        if (!(bus.out_valid === 1'b1 && bus.out_data === eb)) hold_ok = 0;
        tick();
      end
      check($sformatf("bp.hold%0d", i), hold_ok, 1);
      check($sformatf("bp.byte%0d", i), {24'd0, bus.out_data}, {24'd0, eb});
      check($sformatf("bp.no_done%0d", i), {31'd0, bus.done}, 32'd0);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    check("bp.done",        {31'd0, bus.done},      32'd1);
    check("bp.busy",        {31'd0, bus.busy},      32'd0);
    check("bp.no_extra",    {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    tick();

    // start pulses during ITER and EMIT must not disturb the running job (F(7)=13).
    start_job(6'd7);
    tick();
    tick();
    bus.n     = 6'd2;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_valid(lat);
    check("ign.latency", lat + 3, 8);
    bus.out_ready = 1'b0;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    check("ign.busy_emit", {31'd0, bus.busy},     32'd1);
    check("ign.byte0",     {24'd0, bus.out_data}, 32'h0000_000D);
    // ena low masks out_valid immediately and blocks the transfer.
    bus.out_ready = 1'b1;
    ena = 1'b0;
    #1;
    check("ena.valid_low", {31'd0, bus.out_valid}, 32'd0);
    check("ena.data_low",  {24'd0, bus.out_data},  32'd0);
    tick();
    ena = 1'b1;
    #1;
    check("ena.byte0_kept", {24'd0, bus.out_data}, 32'h0000_000D);
    collect(v);
    check("ign.value", v, 32'h0000_000D);
    check("ign.done",  {31'd0, bus.done}, 32'd1);

    // Start in the done cycle is accepted; F(3)=2.
    run_job("b2b_n3", 6'd3, 32'h0000_0002, 1'b0, 4);
    tick();

    // ena low for 7 cycles mid-ITER stretches latency by 7.
    start_job(6'd10);
    tick();
    tick();
    tick();
    ena = 1'b0;
    repeat (7) tick();
    check("stall.busy",  {31'd0, bus.busy},      32'd1);
    check("stall.valid", {31'd0, bus.out_valid}, 32'd0);
    ena = 1'b1;
    wait_valid(lat);
    check("stall.latency", lat + 10, 18);
    collect(v);
    check("stall.value", v, 32'h0000_0037);
    tick();

    // Asynchronous reset after the first byte of an n=20 job.
    bus.out_ready = 1'b1;
    start_job(6'd20);
    wait_valid(lat);
    tick();
    check("rst.byte1", {24'd0, bus.out_data}, 32'h0000_001A);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst.valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst.busy",  {31'd0, bus.busy},      32'd0);
    check("rst.data",  {24'd0, bus.out_data},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_job("post_rst_n6", 6'd6, 32'h0000_0008, 1'b0, 7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
